// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer.
// Detects ECALL/EBREAK/MRET/interrupts in decode, stalls the pipeline,
// writes mepc/mstatus/mcause through the CSR port and redirects fetch.
module trap_ctrl #(
    parameter int unsigned INT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      inst_i,
    input  logic [31:0]      inst_addr_i,
    input  logic             jump_flag_i,
    input  logic [31:0]      jump_addr_i,
    input  logic             div_started_i,
    input  logic [INT_W-1:0] int_flag_i,
    input  logic             global_int_en_i,
    input  logic [31:0]      csr_mtvec_i,
    input  logic [31:0]      csr_mepc_i,
    input  logic [31:0]      csr_mstatus_i,
    output logic             we_o,
    output logic [31:0]      waddr_o,
    output logic [31:0]      raddr_o,
    output logic [31:0]      data_o,
    output logic             hold_flag_o,
    output logic             int_assert_o,
    output logic [31:0]      int_addr_o
);

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_DIV,
        W_MEPC,
        W_MSTATUS,
        W_MCAUSE,
        JUMP,
        W_MRET,
        RET
    } state_t;

    state_t      state, state_n;
    logic [31:0] cause, cause_n;
    logic [31:0] epc, epc_n;
    logic        pend_mret, pend_mret_n;
    logic        pend_int, pend_int_n;

    logic        we_n;
    logic [11:0] waddr_n;
    logic [31:0] data_n;
    logic        int_assert_n;
    logic [31:0] int_addr_n;

    logic        is_ecall, is_ebreak, is_exc, is_mret, is_int, any_event;
    logic [31:0] int_epc;

    assign is_ecall  = (inst_i == INST_ECALL);
    assign is_ebreak = (inst_i == INST_EBREAK);
    assign is_exc    = is_ecall | is_ebreak;
    assign is_mret   = (inst_i == INST_MRET);
    assign is_int    = global_int_en_i & (|int_flag_i);
    assign any_event = is_exc | is_mret | is_int;
    assign int_epc   = jump_flag_i ? jump_addr_i : inst_addr_i;

    // Stall is combinational so the detect cycle itself is already held.
    assign hold_flag_o = (state != IDLE) | any_event;
    assign raddr_o     = '0;

    // Next-state, capture registers and next registered outputs.
    // Outputs are derived from the next state so they appear in the same
    // cycle the FSM occupies the corresponding state.
    always_comb begin
        state_n      = state;
        cause_n      = cause;
        epc_n        = epc;
        pend_mret_n  = pend_mret;
        pend_int_n   = pend_int;
        we_n         = 1'b0;
        waddr_n      = '0;
        data_n       = '0;
        int_assert_n = 1'b0;
        int_addr_n   = '0;

        unique case (state)
            IDLE: begin
                if (is_exc) begin
                    cause_n     = is_ecall ? 32'd11 : 32'd3;
                    epc_n       = inst_addr_i;
                    pend_mret_n = 1'b0;
                    pend_int_n  = 1'b0;
                    state_n     = div_started_i ? WAIT_DIV : W_MEPC;
                end else if (is_mret) begin
                    pend_mret_n = 1'b1;
                    pend_int_n  = 1'b0;
                    state_n     = div_started_i ? WAIT_DIV : W_MRET;
                end else if (is_int) begin
                    cause_n     = int_flag_i[0] ? 32'h8000_0007 : 32'h8000_000B;
                    epc_n       = int_epc;
                    pend_mret_n = 1'b0;
                    pend_int_n  = 1'b1;
                    state_n     = div_started_i ? WAIT_DIV : W_MEPC;
                end
            end
            WAIT_DIV: begin
                if (div_started_i) begin
                    if (pend_int) epc_n = int_epc;
                end else begin
                    state_n = pend_mret ? W_MRET : W_MEPC;
                end
            end
            W_MEPC:    state_n = W_MSTATUS;
            W_MSTATUS: state_n = W_MCAUSE;
            W_MCAUSE:  state_n = JUMP;
            JUMP:      state_n = IDLE;
            W_MRET:    state_n = RET;
            RET:       state_n = IDLE;
            default:   state_n = IDLE;
        endcase

        unique case (state_n)
            W_MEPC: begin
                we_n    = 1'b1;
                waddr_n = CSR_MEPC;
                data_n  = epc_n;
            end
            W_MSTATUS: begin
                we_n    = 1'b1;
                waddr_n = CSR_MSTATUS;
                data_n  = {csr_mstatus_i[31:8], csr_mstatus_i[3],
                           csr_mstatus_i[6:4], 1'b0, csr_mstatus_i[2:0]};
            end
            W_MCAUSE: begin
                we_n    = 1'b1;
                waddr_n = CSR_MCAUSE;
                data_n  = cause_n;
            end
            JUMP: begin
                int_assert_n = 1'b1;
                int_addr_n   = csr_mtvec_i;
            end
            W_MRET: begin
                we_n    = 1'b1;
                waddr_n = CSR_MSTATUS;
                data_n  = {csr_mstatus_i[31:4], csr_mstatus_i[7],
                           csr_mstatus_i[2:0]};
            end
            RET: begin
                int_assert_n = 1'b1;
                int_addr_n   = csr_mepc_i;
            end
            default: ;
        endcase
    end

    // State, capture and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cause        <= '0;
            epc          <= '0;
            pend_mret    <= 1'b0;
            pend_int     <= 1'b0;
            we_o         <= 1'b0;
            waddr_o      <= '0;
            data_o       <= '0;
            int_assert_o <= 1'b0;
            int_addr_o   <= '0;
        end else begin
            state        <= state_n;
            cause        <= cause_n;
            epc          <= epc_n;
            pend_mret    <= pend_mret_n;
            pend_int     <= pend_int_n;
            we_o         <= we_n;
            waddr_o      <= {20'h0, waddr_n};
            data_o       <= data_n;
            int_assert_o <= int_assert_n;
            int_addr_o   <= int_addr_n;
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: table-driven per-cycle check of trap_ctrl plus
// hand-written divider-stall and mid-sequence reset sequences.
module tb_trap_ctrl;

    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] MRET   = 32'h3020_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_i, inst_addr_i, jump_addr_i;
    logic        jump_flag_i, div_started_i, global_int_en_i;
    logic [7:0]  int_flag_i;
    logic [31:0] csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
    logic        we_o, hold_flag_o, int_assert_o;
    logic [31:0] waddr_o, raddr_o, data_o, int_addr_o;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    trap_ctrl #(.INT_W(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .inst_i          (inst_i),
        .inst_addr_i     (inst_addr_i),
        .jump_flag_i     (jump_flag_i),
        .jump_addr_i     (jump_addr_i),
        .div_started_i   (div_started_i),
        .int_flag_i      (int_flag_i),
        .global_int_en_i (global_int_en_i),
        .csr_mtvec_i     (csr_mtvec_i),
        .csr_mepc_i      (csr_mepc_i),
        .csr_mstatus_i   (csr_mstatus_i),
        .we_o            (we_o),
        .waddr_o         (waddr_o),
        .raddr_o         (raddr_o),
        .data_o          (data_o),
        .hold_flag_o     (hold_flag_o),
        .int_assert_o    (int_assert_o),
        .int_addr_o      (int_addr_o)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        jf;
        logic [31:0] ja;
        logic [7:0]  irq;
        logic        gie;
        logic [31:0] mstatus;
        logic        hold;
        logic        we;
        logic [31:0] wa;
        logic [31:0] wd;
        logic        ia;
        logic [31:0] iaddr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [31:0] inst, logic [31:0] pc, logic jf,
                                logic [31:0] ja, logic [7:0] irq, logic gie,
                                logic [31:0] mst, logic hold, logic we,
                                logic [31:0] wa, logic [31:0] wd, logic ia,
                                logic [31:0] iaddr);
        vec_t v;
        v.inst = inst; v.pc = pc; v.jf = jf; v.ja = ja; v.irq = irq;
        v.gie = gie; v.mstatus = mst; v.hold = hold; v.we = we; v.wa = wa;
        v.wd = wd; v.ia = ia; v.iaddr = iaddr;
        return v;
    endfunction

    task automatic chk(input string name, input int unsigned idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got 0x%08h expected 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int unsigned idx, input logic hold, input logic we,
                           input logic [31:0] wa, input logic [31:0] wd,
                           input logic ia, input logic [31:0] iaddr);
        chk("hold_flag_o",  idx, {31'h0, hold_flag_o},  {31'h0, hold});
        chk("we_o",         idx, {31'h0, we_o},         {31'h0, we});
        chk("waddr_o",      idx, waddr_o,               wa);
        chk("data_o",       idx, data_o,                wd);
        chk("int_assert_o", idx, {31'h0, int_assert_o}, {31'h0, ia});
        chk("int_addr_o",   idx, int_addr_o,            iaddr);
        chk("raddr_o",      idx, raddr_o,               32'h0);
    endtask

    task automatic drive(input logic [31:0] inst, input logic [31:0] pc,
                         input logic jf, input logic [31:0] ja, input logic div,
                         input logic [7:0] irq, input logic gie,
                         input logic [31:0] mst);
        inst_i = inst; inst_addr_i = pc; jump_flag_i = jf; jump_addr_i = ja;
        div_started_i = div; int_flag_i = irq; global_int_en_i = gie;
        csr_mstatus_i = mst;
    endtask

    // Advance one cycle: drive just after the rising edge, sample at falling edge.
    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    initial begin
        csr_mtvec_i = 32'h200;
        csr_mepc_i  = 32'h104;
        rst = 1'b1;
        drive(NOP, 32'h0, 1'b0, 32'h0, 1'b0, 8'h00, 1'b0, 32'h0);

        // ECALL, pc=0x100, mstatus=0x8
        vecs.push_back(mk(ECALL, 32'h100, 0, 0, 8'h00, 0, 32'h8, 1, 0, 32'h000, 32'h000, 0, 32'h000));
        vecs.push_back(mk(NOP,   32'h104, 0, 0, 8'h00, 0, 32'h8, 1, 1, 32'h341, 32'h100, 0, 32'h000));
        vecs.push_back(mk(NOP,   32'h104, 0, 0, 8'h00, 0, 32'h8, 1, 1, 32'h300, 32'h080, 0, 32'h000));
        vecs.push_back(mk(NOP,   32'h104, 0, 0, 8'h00, 0, 32'h8, 1, 1, 32'h342, 32'h00B, 0, 32'h000));
        vecs.push_back(mk(NOP,   32'h104, 0, 0, 8'h00, 0, 32'h8, 1, 0, 32'h000, 32'h000, 1, 32'h200));
        vecs.push_back(mk(NOP,   32'h104, 0, 0, 8'h00, 0, 32'h8, 0, 0, 32'h000, 32'h000, 0, 32'h000));
        // Timer interrupt while execute redirects to 0x340
        vecs.push_back(mk(NOP, 32'h180, 1, 32'h340, 8'h01, 1, 32'h8, 1, 0, 32'h000, 32'h000, 0, 32'h000));
        vecs.push_back(mk(NOP, 32'h184, 0, 0,       8'h00, 1, 32'h8, 1, 1, 32'h341, 32'h340, 0, 32'h000));
        vecs.push_back(mk(NOP, 32'h184, 0, 0,       8'h00, 1, 32'h8, 1, 1, 32'h300, 32'h080, 0, 32'h000));
        vecs.push_back(mk(NOP, 32'h184, 0, 0,       8'h00, 1, 32'h8, 1, 1, 32'h342, 32'h8000_0007, 0, 32'h000));
        vecs.push_back(mk(NOP, 32'h184, 0, 0,       8'h00, 1, 32'h8, 1, 0, 32'h000, 32'h000, 1, 32'h200));
        vecs.push_back(mk(NOP, 32'h184, 0, 0,       8'h00, 1, 32'h8, 0, 0, 32'h000, 32'h000, 0, 32'h000));
        // Non-timer interrupt, no redirect: epc = inst_addr_i
        vecs.push_back(mk(NOP, 32'h1C0, 0, 32'h340, 8'h02, 1, 32'h8, 1, 0, 32'h000, 32'h000, 0, 32'h000));
        vecs.push_back(mk(NOP, 32'h1C4, 0, 0,       8'h00, 1, 32'h8, 1, 1, 32'h341, 32'h1C0, 0, 32'h000));
        vecs.push_back(mk(NOP, 32'h1C4, 0, 0,       8'h00, 1, 32'h8, 1, 1, 32'h300, 32'h080, 0, 32'h000));
        vecs.push_back(mk(NOP, 32'h1C4, 0, 0,       8'h00, 1, 32'h8, 1, 1, 32'h342, 32'h8000_000B, 0, 32'h000));
        vecs.push_back(mk(NOP, 32'h1C4, 0, 0,       8'h00, 1, 32'h8, 1, 0, 32'h000, 32'h000, 1, 32'h200));
        vecs.push_back(mk(NOP, 32'h1C4, 0, 0,       8'h00, 1, 32'h8, 0, 0, 32'h000, 32'h000, 0, 32'h000));
        // MRET, mstatus=0x80, mepc=0x104
        vecs.push_back(mk(MRET, 32'h300, 0, 0, 8'h00, 0, 32'h80, 1, 0, 32'h000, 32'h000, 0, 32'h000));
        vecs.push_back(mk(NOP,  32'h304, 0, 0, 8'h00, 0, 32'h80, 1, 1, 32'h300, 32'h088, 0, 32'h000));
        vecs.push_back(mk(NOP,  32'h304, 0, 0, 8'h00, 0, 32'h80, 1, 0, 32'h000, 32'h000, 1, 32'h104));
        vecs.push_back(mk(NOP,  32'h304, 0, 0, 8'h00, 0, 32'h80, 0, 0, 32'h000, 32'h000, 0, 32'h000));
        // Interrupt masked by MIE=0
        vecs.push_back(mk(NOP, 32'h400, 0, 0, 8'h01, 0, 32'h0, 0, 0, 32'h000, 32'h000, 0, 32'h000));
        vecs.push_back(mk(NOP, 32'h404, 0, 0, 8'h01, 0, 32'h0, 0, 0, 32'h000, 32'h000, 0, 32'h000));
        // EBREAK with simultaneous interrupt: exception wins
        vecs.push_back(mk(EBREAK, 32'h120, 0, 0, 8'h01, 1, 32'h8, 1, 0, 32'h000, 32'h000, 0, 32'h000));
        vecs.push_back(mk(NOP,    32'h124, 0, 0, 8'h00, 1, 32'h8, 1, 1, 32'h341, 32'h120, 0, 32'h000));
        vecs.push_back(mk(NOP,    32'h124, 0, 0, 8'h00, 1, 32'h8, 1, 1, 32'h300, 32'h080, 0, 32'h000));
        vecs.push_back(mk(NOP,    32'h124, 0, 0, 8'h00, 1, 32'h8, 1, 1, 32'h342, 32'h003, 0, 32'h000));
        vecs.push_back(mk(NOP,    32'h124, 0, 0, 8'h00, 1, 32'h8, 1, 0, 32'h000, 32'h000, 1, 32'h200));
        vecs.push_back(mk(NOP,    32'h124, 0, 0, 8'h00, 1, 32'h8, 0, 0, 32'h000, 32'h000, 0, 32'h000));

        // Reset state
        next_cycle();
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk_all(0, 0, 0, 32'h0, 32'h0, 0, 32'h0);

        // Table: one row per cycle
        foreach (vecs[i]) begin
            next_cycle();
            drive(vecs[i].inst, vecs[i].pc, vecs[i].jf, vecs[i].ja, 1'b0,
                  vecs[i].irq, vecs[i].gie, vecs[i].mstatus);
            @(negedge clk);
            chk_all(100 + i, vecs[i].hold, vecs[i].we, vecs[i].wa, vecs[i].wd,
                    vecs[i].ia, vecs[i].iaddr);
        end

        // ECALL while divider busy for 5 cycles
        next_cycle();
        drive(ECALL, 32'h100, 1'b0, 32'h0, 1'b1, 8'h00, 1'b0, 32'h8);
        @(negedge clk);
        chk_all(200, 1, 0, 32'h0, 32'h0, 0, 32'h0);
        for (int k = 1; k < 5; k++) begin
            next_cycle();
            drive(NOP, 32'h104, 1'b0, 32'h0, 1'b1, 8'h00, 1'b0, 32'h8);
            @(negedge clk);
            chk_all(200 + k, 1, 0, 32'h0, 32'h0, 0, 32'h0);
        end
        next_cycle();
        drive(NOP, 32'h104, 1'b0, 32'h0, 1'b0, 8'h00, 1'b0, 32'h8);
        @(negedge clk);
        chk_all(205, 1, 0, 32'h0, 32'h0, 0, 32'h0);
        next_cycle();
        @(negedge clk);
        chk_all(206, 1, 1, 32'h341, 32'h100, 0, 32'h0);
        next_cycle();
        @(negedge clk);
        chk_all(207, 1, 1, 32'h300, 32'h080, 0, 32'h0);
        next_cycle();
        @(negedge clk);
        chk_all(208, 1, 1, 32'h342, 32'h00B, 0, 32'h0);
        next_cycle();
        @(negedge clk);
        chk_all(209, 1, 0, 32'h0, 32'h0, 1, 32'h200);
        next_cycle();
        @(negedge clk);
        chk_all(210, 0, 0, 32'h0, 32'h0, 0, 32'h0);

        // Reset asserted during W_MSTATUS aborts the sequence
        next_cycle();
        drive(ECALL, 32'h100, 1'b0, 32'h0, 1'b0, 8'h00, 1'b0, 32'h8);
        @(negedge clk);
        chk_all(300, 1, 0, 32'h0, 32'h0, 0, 32'h0);
        next_cycle();
        drive(NOP, 32'h104, 1'b0, 32'h0, 1'b0, 8'h00, 1'b0, 32'h8);
        @(negedge clk);
        chk_all(301, 1, 1, 32'h341, 32'h100, 0, 32'h0);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk_all(302, 1, 1, 32'h300, 32'h080, 0, 32'h0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk_all(303, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        next_cycle();
        @(negedge clk);
        chk_all(304, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        next_cycle();
        @(negedge clk);
        chk_all(305, 0, 0, 32'h0, 32'h0, 0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time bound so the run always terminates
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
